// File: rtl/axis_pkg.sv
// -----------------------------------------------------------------------------
// axis_pkg
// Items shared by the AXI-Stream width converters (the unpacker now, packer
// blocks later):
//   state_t          FSM encoding of the unpacker: EMPTY / FIRST / SECOND
//   half_width()     output lane width of a packed dual-channel word
//   SEL_LOWER_FIRST  value of `switch` that emits the lower half first
//   SEL_UPPER_FIRST  value of `switch` that emits the upper half first
// -----------------------------------------------------------------------------
package axis_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_t;

  localparam logic SEL_LOWER_FIRST = 1'b1;
  localparam logic SEL_UPPER_FIRST = 1'b0;

  function automatic int half_width(input int w);
    return w / 2;
  endfunction

endpackage

// File: rtl/axis_data_unpacker_if.sv
// -----------------------------------------------------------------------------
// axis_data_unpacker_if
// Bundles both AXI-Stream sides of the unpacker.
//   S_AXIS_*  packed input stream, AXIS_TDATA_WIDTH bits wide
//   M_AXIS_*  unpacked output stream, AXIS_TDATA_WIDTH/2 bits wide
//   M_AXIS_tuser exists only when AXIS_DATA_UNPACKER_CHAN_TAG_EN is defined.
// Modports:
//   slave   the unpacker's view (consumes S_AXIS, produces M_AXIS)
//   master  the surrounding environment's view
// Handshake: a transfer happens on a rising aclk edge where tvalid and tready
// are both high; a source holds tdata/tvalid/tlast/tuser stable while
// tvalid is high and tready is low.
// -----------------------------------------------------------------------------
interface axis_data_unpacker_if
  import axis_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32
);
  localparam int HW = half_width(AXIS_TDATA_WIDTH);

  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata;
  logic                        S_AXIS_tvalid;
  logic                        S_AXIS_tready;
  logic                        M_AXIS_tready;
  logic [HW-1:0]               M_AXIS_tdata;
  logic                        M_AXIS_tvalid;
  logic                        M_AXIS_tlast;
`ifdef AXIS_DATA_UNPACKER_CHAN_TAG_EN
  logic                        M_AXIS_tuser;
`endif

  modport slave (
    input  S_AXIS_tdata, S_AXIS_tvalid, M_AXIS_tready,
    output S_AXIS_tready, M_AXIS_tdata, M_AXIS_tvalid, M_AXIS_tlast
`ifdef AXIS_DATA_UNPACKER_CHAN_TAG_EN
    , output M_AXIS_tuser
`endif
  );

  modport master (
    output S_AXIS_tdata, S_AXIS_tvalid, M_AXIS_tready,
    input  S_AXIS_tready, M_AXIS_tdata, M_AXIS_tvalid, M_AXIS_tlast
`ifdef AXIS_DATA_UNPACKER_CHAN_TAG_EN
    , input M_AXIS_tuser
`endif
  );

endinterface

// File: rtl/axis_half_select.sv
// -----------------------------------------------------------------------------
// axis_half_select
// Combinational pick of one half of a packed {upper, lower} word.
//   word       packed word, WIDTH bits
//   sel        order select: SEL_LOWER_FIRST or SEL_UPPER_FIRST
//   second     beat index within the pair: 0 = first beat, 1 = second beat
//   half       selected half, WIDTH/2 bits
//   src_upper  1 when `half` came from the upper half of `word`
// -----------------------------------------------------------------------------
module axis_half_select
  import axis_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]             word,
  input  logic                         sel,
  input  logic                         second,
  output logic [half_width(WIDTH)-1:0] half,
  output logic                         src_upper
);
  localparam int HW = half_width(WIDTH);

  logic pick_lower;

  always_comb begin
    // The second beat is always the half the first beat did not use.
    pick_lower = second ? (sel == SEL_UPPER_FIRST) : (sel == SEL_LOWER_FIRST);
    half       = pick_lower ? word[HW-1:0] : word[WIDTH-1:HW];
    src_upper  = ~pick_lower;
  end

endmodule

// File: rtl/axis_data_unpacker.sv
// -----------------------------------------------------------------------------
// axis_data_unpacker
// Splits each packed dual-channel word {upper, lower} into two consecutive
// half-width output beats. `switch` (captured on accept) chooses which half
// goes first; M_AXIS_tlast marks the second beat of each pair.
// Ports:
//   aclk       clock, rising edge
//   aresetn    synchronous active-low reset
//   switch     1 = lower half first, 0 = upper half first
//   axis       slave modport of axis_data_unpacker_if (S_AXIS_* / M_AXIS_*)
//   state_dbg  current FSM state, for observation only
// Optional feature: AXIS_DATA_UNPACKER_CHAN_TAG_EN adds M_AXIS_tuser, the
// source half of the current beat (0 = lower, 1 = upper).
// AXIS_TDATA_WIDTH must be even and at least 4.
// -----------------------------------------------------------------------------
module axis_data_unpacker
  import axis_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   switch,
  axis_data_unpacker_if.slave    axis,
  output state_t                 state_dbg
);
  localparam int HW = half_width(AXIS_TDATA_WIDTH);

  state_t                      state_q, state_d;
  logic [AXIS_TDATA_WIDTH-1:0] hold_q;
  logic                        sw_q;
  logic                        s_ready;
  logic                        m_valid;
  logic                        m_last;
  logic                        accept;
  logic [HW-1:0]               half;
`ifdef AXIS_DATA_UNPACKER_CHAN_TAG_EN
  logic                        src_upper;
`else
  logic                        unused_src_upper;
`endif

  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    case (state_q)
      EMPTY: begin
        s_ready = 1'b1;
        if (axis.S_AXIS_tvalid) state_d = FIRST;
      end
      FIRST: begin
        m_valid = 1'b1;
        if (axis.M_AXIS_tready) state_d = SECOND;
      end
      SECOND: begin
        m_valid = 1'b1;
        m_last  = 1'b1;
        // Taking the next word while the second beat leaves keeps the
        // output busy every cycle under continuous flow.
        s_ready = axis.M_AXIS_tready;
        if (axis.M_AXIS_tready) state_d = axis.S_AXIS_tvalid ? FIRST : EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Ready is forced low while reset is asserted so no accept is signalled
  // in a cycle that reset voids.
  assign axis.S_AXIS_tready = aresetn & s_ready;
  assign accept             = axis.S_AXIS_tvalid & axis.S_AXIS_tready;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= EMPTY;
      hold_q  <= '0;
      sw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        hold_q <= axis.S_AXIS_tdata;
        sw_q   <= switch;
      end
    end
  end

  axis_half_select #(.WIDTH(AXIS_TDATA_WIDTH)) u_half_select (
    .word      (hold_q),
    .sel       (sw_q),
    .second    (state_q == SECOND),
    .half      (half),
`ifdef AXIS_DATA_UNPACKER_CHAN_TAG_EN
    .src_upper (src_upper)
`else
    .src_upper (unused_src_upper)
`endif
  );

  // Outputs depend only on registered state and the holding register.
  assign axis.M_AXIS_tvalid = m_valid;
  assign axis.M_AXIS_tlast  = m_last;
  assign axis.M_AXIS_tdata  = m_valid ? half : '0;
`ifdef AXIS_DATA_UNPACKER_CHAN_TAG_EN
  assign axis.M_AXIS_tuser  = m_valid & src_upper;
`endif
  assign state_dbg          = state_q;

endmodule

// File: tb/tb_axis_data_unpacker.sv
// -----------------------------------------------------------------------------
// tb_axis_data_unpacker
// Directed and randomised checks of axis_data_unpacker. Inputs change 1 time
// unit after the rising edge; outputs are sampled on the falling edge.
// Expected beats are kept as {tlast, tuser, tdata}; tuser is compared only
// when AXIS_DATA_UNPACKER_CHAN_TAG_EN is defined.
// -----------------------------------------------------------------------------
module tb_axis_data_unpacker;
  import axis_pkg::*;

  localparam int W  = 32;
  localparam int HW = 16;

  logic   aclk    = 1'b0;
  logic   aresetn = 1'b0;
  logic   sw      = 1'b0;
  state_t state_dbg;

  int total = 0;
  int bad   = 0;
  logic [HW+1:0] exp_q[$];

  axis_data_unpacker_if #(.AXIS_TDATA_WIDTH(W)) bus ();

  axis_data_unpacker #(.AXIS_TDATA_WIDTH(W)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .switch    (sw),
    .axis      (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 aclk = ~aclk;

  logic m_user;
`ifdef AXIS_DATA_UNPACKER_CHAN_TAG_EN
  assign m_user = bus.M_AXIS_tuser;
  localparam logic [HW+1:0] CMP_MASK = '1;
`else
  assign m_user = 1'b0;
  localparam logic [HW+1:0] CMP_MASK = {1'b1, 1'b0, {HW{1'b1}}};
`endif

  // ---------------- driver ----------------
  task automatic cycle(input logic rst_n, input logic s_valid,
                       input logic [W-1:0] data, input logic s_sw,
                       input logic m_ready);
    @(posedge aclk);
    #1;
    aresetn           = rst_n;
    bus.S_AXIS_tvalid = s_valid;
    bus.S_AXIS_tdata  = data;
    sw                = s_sw;
    bus.M_AXIS_tready = m_ready;
    @(negedge aclk);
  endtask

  // Reference beat: first beat takes the lower half when sel=1, else upper;
  // the second beat takes the remaining half. tuser = 1 for the upper half.
  function automatic logic [HW+1:0] ref_beat(input logic [W-1:0] word,
                                             input logic sel, input logic second);
    logic lower;
    lower = second ? !sel : sel;
    return {second, !lower, lower ? word[HW-1:0] : word[W-1:HW]};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
      total++;
      if (bus.M_AXIS_tvalid !== 1'b0) begin
        bad++; $display("FAIL reset_tvalid: got %b want 0", bus.M_AXIS_tvalid);
      end
      total++;
      if (bus.M_AXIS_tdata !== 16'h0000) begin
        bad++; $display("FAIL reset_tdata: got %h want 0000", bus.M_AXIS_tdata);
      end
      total++;
      if (bus.S_AXIS_tready !== 1'b0) begin
        bad++; $display("FAIL reset_s_tready: got %b want 0", bus.S_AXIS_tready);
      end
    end
    cycle(1'b1, 1'b1, 32'h11112222, 1'b1, 1'b1);
    total++;
    if (bus.S_AXIS_tready !== 1'b1 || state_dbg !== EMPTY) begin
      bad++; $display("FAIL release_accept: got tready=%b state=%0d want 1/EMPTY",
                      bus.S_AXIS_tready, state_dbg);
    end
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    total++;
    if ({bus.M_AXIS_tvalid, bus.M_AXIS_tlast, bus.M_AXIS_tdata} !== {2'b10, 16'h2222}) begin
      bad++; $display("FAIL release_beat0: got v=%b l=%b d=%h want 1/0/2222",
                      bus.M_AXIS_tvalid, bus.M_AXIS_tlast, bus.M_AXIS_tdata);
    end
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    total++;
    if ({bus.M_AXIS_tvalid, bus.M_AXIS_tlast, bus.M_AXIS_tdata} !== {2'b11, 16'h1111}) begin
      bad++; $display("FAIL release_beat1: got v=%b l=%b d=%h want 1/1/1111",
                      bus.M_AXIS_tvalid, bus.M_AXIS_tlast, bus.M_AXIS_tdata);
    end
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    total++;
    if (bus.M_AXIS_tvalid !== 1'b0) begin
      bad++; $display("FAIL release_idle: got tvalid=%b want 0", bus.M_AXIS_tvalid);
    end
  endtask

  task automatic test_order(input logic sel, input logic [W-1:0] word,
                            input logic [HW-1:0] exp0, input logic [HW-1:0] exp1);
    cycle(1'b1, 1'b1, word, sel, 1'b1);
    total++;
    if (bus.S_AXIS_tready !== 1'b1) begin
      bad++; $display("FAIL order_accept sel=%b: got tready=%b want 1", sel, bus.S_AXIS_tready);
    end
    // switch flips here: the stored order must not change
    cycle(1'b1, 1'b0, 32'h0, ~sel, 1'b1);
    total++;
    if ({bus.M_AXIS_tvalid, bus.M_AXIS_tlast, bus.M_AXIS_tdata, bus.S_AXIS_tready}
        !== {2'b10, exp0, 1'b0}) begin
      bad++; $display("FAIL order_first sel=%b: got v=%b l=%b d=%h r=%b want 1/0/%h/0",
                      sel, bus.M_AXIS_tvalid, bus.M_AXIS_tlast, bus.M_AXIS_tdata,
                      bus.S_AXIS_tready, exp0);
    end
    cycle(1'b1, 1'b0, 32'h0, ~sel, 1'b1);
    total++;
    if ({bus.M_AXIS_tvalid, bus.M_AXIS_tlast, bus.M_AXIS_tdata} !== {2'b11, exp1}) begin
      bad++; $display("FAIL order_second sel=%b: got v=%b l=%b d=%h want 1/1/%h",
                      sel, bus.M_AXIS_tvalid, bus.M_AXIS_tlast, bus.M_AXIS_tdata, exp1);
    end
    cycle(1'b1, 1'b0, 32'h0, sel, 1'b1);
    total++;
    if (bus.M_AXIS_tvalid !== 1'b0) begin
      bad++; $display("FAIL order_idle sel=%b: got tvalid=%b want 0", sel, bus.M_AXIS_tvalid);
    end
  endtask

  task automatic test_back_to_back();
    int widx = 0;
    logic [W-1:0] word;
    logic [HW+1:0] got, exp;
    exp_q.delete();
    for (int cyc = 0; cyc <= 16; cyc++) begin
      word = {16'(widx + 1), 16'(widx)};
      cycle(1'b1, widx < 8, word, 1'b1, 1'b1);
      if (cyc >= 1) begin
        total++;
        if (bus.M_AXIS_tvalid !== 1'b1) begin
          bad++; $display("FAIL stream_bubble cyc=%0d: got tvalid=%b want 1", cyc, bus.M_AXIS_tvalid);
        end
      end
      total++;
      if (bus.S_AXIS_tready !== ((cyc % 2) == 0)) begin
        bad++; $display("FAIL stream_s_tready cyc=%0d: got %b want %b",
                        cyc, bus.S_AXIS_tready, (cyc % 2) == 0);
      end
      if (bus.M_AXIS_tvalid === 1'b1) begin
        got = {bus.M_AXIS_tlast, m_user, bus.M_AXIS_tdata};
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        total++;
        if ((got & CMP_MASK) !== (exp & CMP_MASK)) begin
          bad++; $display("FAIL stream_beat cyc=%0d: got %h want %h", cyc, got, exp);
        end
      end
      if (bus.S_AXIS_tvalid === 1'b1 && bus.S_AXIS_tready === 1'b1) begin
        exp_q.push_back(ref_beat(word, 1'b1, 1'b0));
        exp_q.push_back(ref_beat(word, 1'b1, 1'b1));
        widx++;
      end
    end
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    total++;
    if (bus.M_AXIS_tvalid !== 1'b0 || exp_q.size() != 0 || widx != 8) begin
      bad++; $display("FAIL stream_end: got tvalid=%b left=%0d words=%0d want 0/0/8",
                      bus.M_AXIS_tvalid, exp_q.size(), widx);
    end
  endtask

  // Random valid/ready/data. toggle_sw=1 flips switch every cycle.
  task automatic test_backpressure(input int n_words, input logic toggle_sw, input string name);
    int left = n_words;
    int cyc  = 0;
    logic stall = 1'b0;
    logic cur_sw = 1'b0;
    logic [HW+1:0] prev, got, exp;
    exp_q.delete();
    while ((left > 0 || exp_q.size() > 0) && cyc < 20000) begin
      cur_sw = toggle_sw ? ~cur_sw : 1'($urandom_range(0, 1));
      cycle(1'b1, (left > 0) ? 1'($urandom_range(0, 1)) : 1'b0, $urandom, cur_sw,
            1'($urandom_range(0, 1)));
      got = {bus.M_AXIS_tlast, m_user, bus.M_AXIS_tdata};
      if (stall) begin
        total++;
        if (bus.M_AXIS_tvalid !== 1'b1 || (got & CMP_MASK) !== (prev & CMP_MASK)) begin
          bad++; $display("FAIL %s_stable cyc=%0d: got v=%b %h want 1 %h",
                          name, cyc, bus.M_AXIS_tvalid, got, prev);
        end
      end
      if (bus.M_AXIS_tvalid === 1'b1 && bus.M_AXIS_tready === 1'b1) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        total++;
        if ((got & CMP_MASK) !== (exp & CMP_MASK)) begin
          bad++; $display("FAIL %s_beat cyc=%0d: got %h want %h", name, cyc, got, exp);
        end
      end
      if (bus.S_AXIS_tvalid === 1'b1 && bus.S_AXIS_tready === 1'b1) begin
        exp_q.push_back(ref_beat(bus.S_AXIS_tdata, cur_sw, 1'b0));
        exp_q.push_back(ref_beat(bus.S_AXIS_tdata, cur_sw, 1'b1));
        left--;
      end
      stall = bus.M_AXIS_tvalid & ~bus.M_AXIS_tready;
      prev  = got;
      cyc++;
    end
    total++;
    if (left != 0 || exp_q.size() != 0) begin
      bad++; $display("FAIL %s_complete: got words_left=%0d beats_left=%0d want 0/0",
                      name, left, exp_q.size());
    end
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_mid_pair_reset();
    cycle(1'b1, 1'b1, 32'hAAAABBBB, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    total++;
    if (state_dbg !== SECOND ||
        {bus.M_AXIS_tvalid, bus.M_AXIS_tlast, bus.M_AXIS_tdata} !== {2'b11, 16'hAAAA}) begin
      bad++; $display("FAIL midrst_second: got st=%0d v=%b l=%b d=%h want SECOND 1/1/aaaa",
                      state_dbg, bus.M_AXIS_tvalid, bus.M_AXIS_tlast, bus.M_AXIS_tdata);
    end
    // reset together with emit and offered word: both handshakes void
    cycle(1'b0, 1'b1, 32'h99998888, 1'b1, 1'b1);
    total++;
    if (bus.S_AXIS_tready !== 1'b0) begin
      bad++; $display("FAIL midrst_s_tready: got %b want 0", bus.S_AXIS_tready);
    end
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    total++;
    if (bus.M_AXIS_tvalid !== 1'b0 || state_dbg !== EMPTY) begin
      bad++; $display("FAIL midrst_flush: got tvalid=%b st=%0d want 0/EMPTY",
                      bus.M_AXIS_tvalid, state_dbg);
    end
    cycle(1'b1, 1'b1, 32'h12345678, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    total++;
    if ({bus.M_AXIS_tvalid, bus.M_AXIS_tlast, bus.M_AXIS_tdata} !== {2'b10, 16'h5678}) begin
      bad++; $display("FAIL midrst_beat0: got v=%b l=%b d=%h want 1/0/5678",
                      bus.M_AXIS_tvalid, bus.M_AXIS_tlast, bus.M_AXIS_tdata);
    end
`ifdef AXIS_DATA_UNPACKER_CHAN_TAG_EN
    total++;
    if (bus.M_AXIS_tuser !== 1'b0) begin
      bad++; $display("FAIL midrst_tuser0: got %b want 0", bus.M_AXIS_tuser);
    end
`endif
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    total++;
    if ({bus.M_AXIS_tvalid, bus.M_AXIS_tlast, bus.M_AXIS_tdata} !== {2'b11, 16'h1234}) begin
      bad++; $display("FAIL midrst_beat1: got v=%b l=%b d=%h want 1/1/1234",
                      bus.M_AXIS_tvalid, bus.M_AXIS_tlast, bus.M_AXIS_tdata);
    end
`ifdef AXIS_DATA_UNPACKER_CHAN_TAG_EN
    total++;
    if (bus.M_AXIS_tuser !== 1'b1) begin
      bad++; $display("FAIL midrst_tuser1: got %b want 1", bus.M_AXIS_tuser);
    end
`endif
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    total++;
    if (bus.M_AXIS_tvalid !== 1'b0) begin
      bad++; $display("FAIL midrst_idle: got tvalid=%b want 0", bus.M_AXIS_tvalid);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.S_AXIS_tvalid = 1'b0;
    bus.S_AXIS_tdata  = '0;
    bus.M_AXIS_tready = 1'b0;
    test_reset();
    test_order(1'b1, 32'hAAAA5555, 16'h5555, 16'hAAAA);
    test_order(1'b0, 32'hAAAA5555, 16'hAAAA, 16'h5555);
    test_back_to_back();
    test_backpressure(1000, 1'b0, "bp");
    test_backpressure(200, 1'b1, "latch_sw");
    test_mid_pair_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
